// File: rtl/bin_to_bcd6.sv
// Sequential double-dabble converter: BIN_W-bit binary count to six packed BCD digits,
// saturating at 999999 with an overflow flag.
module bin_to_bcd6 #(
    parameter int BIN_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic [3:0]       hundred_thousands_out,
    output logic [3:0]       ten_thousands_out,
    output logic [3:0]       thousands_out,
    output logic [3:0]       hundreds_out,
    output logic [3:0]       tens_out,
    output logic [3:0]       units_out,
    output logic             busy,
    output logic             overflow,
    output logic             done
);

    // state    | meaning
    // S_IDLE   | waiting for start, outputs hold last result
    // S_SHIFT  | BIN_W add-3/shift steps
    // S_FINISH | publish digits and overflow, pulse done
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    localparam logic [4:0]  LAST_CNT = 5'(BIN_W - 1);
    localparam logic [23:0] BCD_MAX  = 24'h999999;

    logic [1:0]       state;
    logic [BIN_W-1:0] bin_sr;
    logic [23:0]      scratch;
    logic [23:0]      corr;
    logic [4:0]       cnt;
    logic             sat;
    logic [23:0]      digits;

    always_comb begin
        corr = '0;
        for (int i = 0; i < 6; i++) begin
            corr[i*4 +: 4] = (scratch[i*4 +: 4] >= 4'd5) ? scratch[i*4 +: 4] + 4'd3
                                                          : scratch[i*4 +: 4];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            bin_sr   <= '0;
            scratch  <= '0;
            cnt      <= '0;
            sat      <= 1'b0;
            digits   <= '0;
            busy     <= 1'b0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        bin_sr  <= bin_in;
                        scratch <= '0;
                        cnt     <= '0;
                        sat     <= (24'(bin_in) > 24'd999999);
                        busy    <= 1'b1;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // Top bit of the corrected scratch falls off; only reachable when sat=1.
                    {scratch, bin_sr} <= {corr, bin_sr} << 1;
                    cnt <= cnt + 5'd1;
                    if (cnt == LAST_CNT) begin
                        state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    digits   <= sat ? BCD_MAX : scratch;
                    overflow <= sat;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign hundred_thousands_out = digits[23:20];
    assign ten_thousands_out     = digits[19:16];
    assign thousands_out         = digits[15:12];
    assign hundreds_out          = digits[11:8];
    assign tens_out              = digits[7:4];
    assign units_out             = digits[3:0];

endmodule

// File: doc/bin_to_bcd6.md
Name: bin_to_bcd6

Overview:
- Sequential double-dabble (shift-add-3) converter that turns the frequency counter's binary count into six packed BCD digits.
- Sits directly upstream of the BCD rounding stage.
- Its digit outputs and one-cycle done pulse connect directly to that stage's digit inputs and start input.
- Inputs above 999999 saturate to 999999 and are flagged.

Parameters:
- BIN_W, 20, width of the binary input. Legal range is 20..24. The shift phase lasts exactly BIN_W cycles.

Ports:
- clk  input  1  system clock, all logic on the rising edge
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  request conversion of bin_in; sampled only in IDLE
- bin_in  input  BIN_W  unsigned binary value; captured on the accepting edge
- hundred_thousands_out  output  4  BCD digit 5 (most significant)
- ten_thousands_out  output  4  BCD digit 4
- thousands_out  output  4  BCD digit 3
- hundreds_out  output  4  BCD digit 2
- tens_out  output  4  BCD digit 1
- units_out  output  4  BCD digit 0
- busy  output  1  high while a conversion is in progress (SHIFT or FINISH)
- overflow  output  1  set when the last converted value exceeded 999999
- done  output  1  one-cycle pulse; digits and overflow are valid and stable from this cycle on

Behaviour:
- Reset: on any rising edge with rst_n=0, the following are cleared and state goes to IDLE:
  - all six digit outputs = 0
  - done = 0, busy = 0, overflow = 0
  - internal scratch register and bit counter
- Reset mid-conversion aborts the conversion; no done is produced.
- FSM states: IDLE, SHIFT, FINISH.
- IDLE:
  - If start=1 on an edge, latch bin_in into the shift register and clear the BCD scratch (24 bits) and the bit counter.
  - On the same edge, latch sat = (bin_in > 999999), set busy=1, and go to SHIFT.
  - If start=0, remain in IDLE.
- SHIFT:
  - Each cycle, apply the add-3 correction to every scratch nibble that is >= 5, then shift the {scratch, binary} concatenation left by one bit.
  - The counter increments each cycle. After exactly BIN_W shift cycles, go to FINISH.
- FINISH (one cycle):
  - If sat=0, copy the scratch nibbles to the digit outputs (units = least significant nibble).
  - If sat=1, drive all six digits to 9.
  - Set overflow=sat, pulse done=1, clear busy, and go to IDLE.
- Latency: a start accepted at edge E0 gives done=1 in the cycle following edge E0+BIN_W+1 (21 clocks at default).
- Handshake rules:
  - start while busy=1 is ignored and not queued.
  - start asserted during the done cycle is accepted, because the FSM is already in IDLE. Back-to-back throughput is one conversion per BIN_W+1 cycles.
  - A start held high continuously restarts a conversion immediately after each done.
- Output timing:
  - done is high for exactly one cycle per completed conversion and is 0 otherwise.
  - Digits and overflow change only on the edge that raises done, and hold between conversions.
  - bin_in changes after the accepting edge have no effect.
- Arithmetic:
  - Scratch nibbles never exceed 9 after correction.
  - No carry out of digit 5 can occur for values <= 999999. Larger values are covered by saturation, so the scratch contents are don't-care when sat=1.
  - Every digit output is always a valid BCD value (0..9).

Test Plan:
- Reset, then start with bin_in=0 -> done after 21 clocks; all digits 0; overflow=0; busy high for exactly 21 cycles.
- bin_in=123456 -> digits 1,2,3,4,5,6 (most to least significant); done is a single-cycle pulse; outputs hold 123456 for 50 idle cycles afterwards.
- bin_in=999999, then 1000000, then 20'hFFFFF -> first result 999999 with overflow=0; second and third results 999999 with overflow=1. A following bin_in=5 clears overflow and gives digits 000005.
- Start with 654321, then pulse start with 111111 at clocks 5 and 15 of that conversion -> only 654321 is produced; exactly one done; the extra starts are ignored.
- start held high with bin_in switching to 987654 during the done cycle -> second conversion accepted on the done edge; second done exactly 21 clocks after the first; digits 987654.
- Start 500000, drop rst_n for one edge at clock 10 of the conversion -> all outputs 0 and busy=0 on the next edge; no done appears. A following start with 42 converts to 000042 normally.
